// File: rtl/pe_conv_sequencer_if.sv
// pe_conv_sequencer_if: operand-fetch and result valid/ready channels of the conv sequencer.
// master = sequencer side, slave = fetch unit / result writer side.
interface pe_conv_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int N_REG = 31,
  parameter int CNT_W = 16
) ();
  logic                   fetch_req;
  logic [CNT_W-1:0]       fetch_pos;
  logic [CNT_W-1:0]       fetch_ch;
  logic                   fetch_ack;
  logic [N_REG*WIDTH-1:0] fetch_a;
  logic [N_REG*WIDTH-1:0] fetch_w;
  logic [WIDTH-1:0]       fetch_b;

  logic                   res_valid;
  logic                   res_ready;
  logic [WIDTH-1:0]       res_data;
  logic [CNT_W-1:0]       res_pos;
  logic [CNT_W-1:0]       res_ch;
  logic                   res_last;

  modport master (
    output fetch_req, fetch_pos, fetch_ch,
    input  fetch_ack, fetch_a, fetch_w, fetch_b,
    output res_valid, res_data, res_pos, res_ch, res_last,
    input  res_ready
  );

  modport slave (
    input  fetch_req, fetch_pos, fetch_ch,
    output fetch_ack, fetch_a, fetch_w, fetch_b,
    input  res_valid, res_data, res_pos, res_ch, res_last,
    output res_ready
  );
endinterface

// File: rtl/pe_conv_sequencer.sv
// pe_conv_sequencer: drives one combinational PE across a conv layer, ch inner / pos outer.
// Optional macro SEQ_RELU_EN clamps negative PE results to zero before they are emitted.
module pe_conv_sequencer #(
  parameter int WIDTH = 32,
  parameter int FBITS = 24,
  parameter int N_REG = 31,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [CNT_W-1:0]       cfg_n_pos,
  input  logic [CNT_W-1:0]       cfg_n_ch,
  output logic                   busy,
  output logic                   done,
  pe_conv_sequencer_if.master    bus,
  output logic [N_REG*WIDTH-1:0] pe_all_a,
  output logic [N_REG*WIDTH-1:0] pe_all_w,
  output logic [WIDTH-1:0]       pe_b,
  input  logic [WIDTH-1:0]       pe_y
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_COMPUTE = 3'd2;
  localparam logic [2:0] S_OUTPUT  = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  // FBITS only describes the PE's number format; reject nonsensical values at elaboration.
  if (FBITS < 0 || FBITS >= WIDTH) begin : g_bad_fbits
    $error("pe_conv_sequencer: FBITS must lie in [0, WIDTH)");
  end

  logic [2:0]       state;
  logic [CNT_W-1:0] n_pos;
  logic [CNT_W-1:0] n_ch;
  logic [CNT_W-1:0] pos;
  logic [CNT_W-1:0] ch;
  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic [CNT_W-1:0] res_pos;
  logic [CNT_W-1:0] res_ch;
  logic [WIDTH-1:0] y_out;
  logic             last_ch;
  logic             last_pos;

  assign last_ch  = (ch  == n_ch  - CNT_W'(1));
  assign last_pos = (pos == n_pos - CNT_W'(1));

`ifdef SEQ_RELU_EN
  assign y_out = pe_y[WIDTH-1] ? '0 : pe_y;
`else
  assign y_out = pe_y;
`endif

  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE);
  assign bus.fetch_req = (state == S_FETCH);
  assign bus.fetch_pos = pos;
  assign bus.fetch_ch  = ch;
  assign bus.res_valid = res_valid;
  assign bus.res_data  = res_data;
  assign bus.res_pos   = res_pos;
  assign bus.res_ch    = res_ch;
  assign bus.res_last  = res_valid && last_pos && last_ch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      n_pos     <= '0;
      n_ch      <= '0;
      pos       <= '0;
      ch        <= '0;
      pe_all_a  <= '0;
      pe_all_w  <= '0;
      pe_b      <= '0;
      res_valid <= '0;
      res_data  <= '0;
      res_pos   <= '0;
      res_ch    <= '0;
    end else if (abort && state != S_IDLE) begin
      // Abort wins over ack/ready; datapath registers deliberately keep their values.
      state     <= S_IDLE;
      res_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            n_pos <= cfg_n_pos;
            n_ch  <= cfg_n_ch;
            pos   <= '0;
            ch    <= '0;
            state <= (cfg_n_pos == '0 || cfg_n_ch == '0) ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: begin
          if (bus.fetch_ack) begin
            pe_all_a <= bus.fetch_a;
            pe_all_w <= bus.fetch_w;
            pe_b     <= bus.fetch_b;
            state    <= S_COMPUTE;
          end
        end
        S_COMPUTE: begin
          res_data  <= y_out;
          res_pos   <= pos;
          res_ch    <= ch;
          res_valid <= 1'b1;
          state     <= S_OUTPUT;
        end
        S_OUTPUT: begin
          if (bus.res_ready) begin
            res_valid <= 1'b0;
            if (last_ch) begin
              ch  <= '0;
              pos <= pos + CNT_W'(1);
            end else begin
              ch <= ch + CNT_W'(1);
            end
            state <= (last_ch && last_pos) ? S_DONE : S_FETCH;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_conv_sequencer.sv
// tb_pe_conv_sequencer: randomized scenarios against a layer-level reference of the conv sequencer.
// The PE is modelled here as a plain Q-format dot product plus bias.
module tb_pe_conv_sequencer;
  localparam int WIDTH = 32;
  localparam int FBITS = 24;
  localparam int N_REG = 31;
  localparam int CNT_W = 16;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   start = 1'b0;
  logic                   abort = 1'b0;
  logic [CNT_W-1:0]       cfg_n_pos = '0;
  logic [CNT_W-1:0]       cfg_n_ch = '0;
  logic                   busy;
  logic                   done;
  logic [N_REG*WIDTH-1:0] pe_all_a;
  logic [N_REG*WIDTH-1:0] pe_all_w;
  logic [WIDTH-1:0]       pe_b;
  logic [WIDTH-1:0]       pe_y;

  int vectors = 0;
  int errors  = 0;

  pe_conv_sequencer_if #(.WIDTH(WIDTH), .N_REG(N_REG), .CNT_W(CNT_W)) bus ();

  pe_conv_sequencer #(.WIDTH(WIDTH), .FBITS(FBITS), .N_REG(N_REG), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .cfg_n_pos (cfg_n_pos),
    .cfg_n_ch  (cfg_n_ch),
    .busy      (busy),
    .done      (done),
    .bus       (bus),
    .pe_all_a  (pe_all_a),
    .pe_all_w  (pe_all_w),
    .pe_b      (pe_b),
    .pe_y      (pe_y)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] pe_fn(input logic [N_REG*WIDTH-1:0] a,
                                             input logic [N_REG*WIDTH-1:0] w,
                                             input logic [WIDTH-1:0] b);
    longint acc;
    acc = 0;
    for (int i = 0; i < N_REG; i++)
      acc += longint'($signed(a[i*WIDTH +: WIDTH])) * longint'($signed(w[i*WIDTH +: WIDTH]));
    return b + WIDTH'(acc >>> FBITS);
  endfunction

  assign pe_y = pe_fn(pe_all_a, pe_all_w, pe_b);

  function automatic logic [WIDTH-1:0] expect_out(input logic [WIDTH-1:0] y);
`ifdef SEQ_RELU_EN
    return ($signed(y) < 0) ? '0 : y;
`else
    return y;
`endif
  endfunction

  function automatic logic [N_REG*WIDTH-1:0] rand_win();
    logic [N_REG*WIDTH-1:0] v;
    for (int i = 0; i < N_REG; i++) v[i*WIDTH +: WIDTH] = $urandom;
    return v;
  endfunction

  function automatic int outs_set();
    return $countones({busy, done, bus.fetch_req, bus.fetch_pos, bus.fetch_ch, bus.res_valid,
                       bus.res_data, bus.res_pos, bus.res_ch, bus.res_last,
                       pe_all_a, pe_all_w, pe_b});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) step();
    vectors++;
    if (outs_set() !== 0) begin
      errors++;
      $display("FAIL reset_state: %0d output bits set, expected 0", outs_set());
    end
    rst_n = 1'b1;
    step();
    vectors++;
    if (outs_set() !== 0) begin
      errors++;
      $display("FAIL reset_release: %0d output bits set, expected 0", outs_set());
    end
  endtask

  // Full layer walk; every result is checked for value, tags, last flag, cycle position and stall stability.
  task automatic test_layer(input int np, input int nc, input int ack_max,
                            input int rdy_min, input int rdy_max);
    logic [WIDTH-1:0] exp;
    logic             exp_last;
    int               d;
    cfg_n_pos = CNT_W'(np);
    cfg_n_ch  = CNT_W'(nc);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int p = 0; p < np; p++) begin
      for (int c = 0; c < nc; c++) begin
        vectors++;
        if (bus.fetch_req !== 1'b1 || bus.fetch_pos !== CNT_W'(p) || bus.fetch_ch !== CNT_W'(c)) begin
          errors++;
          $display("FAIL fetch_req: got req=%b pos=%0d ch=%0d, expected req=1 pos=%0d ch=%0d",
                   bus.fetch_req, bus.fetch_pos, bus.fetch_ch, p, c);
        end
        d = int'($urandom_range(ack_max, 0));
        repeat (d) begin
          start     = 1'($urandom_range(1, 0));
          cfg_n_pos = CNT_W'($urandom);
          cfg_n_ch  = CNT_W'($urandom);
          step();
        end
        start = 1'b0;
        bus.fetch_a = rand_win();
        bus.fetch_w = rand_win();
        bus.fetch_b = $urandom;
        bus.fetch_ack = 1'b1;
        exp = expect_out(pe_fn(bus.fetch_a, bus.fetch_w, bus.fetch_b));
        step();
        bus.fetch_ack = 1'b0;
        bus.fetch_a = rand_win();
        bus.fetch_w = rand_win();
        bus.fetch_b = $urandom;
        vectors++;
        if (bus.res_valid !== 1'b0 || bus.fetch_req !== 1'b0) begin
          errors++;
          $display("FAIL compute_cycle: got valid=%b req=%b, expected valid=0 req=0",
                   bus.res_valid, bus.fetch_req);
        end
        step();
        exp_last = (p == np - 1) && (c == nc - 1);
        vectors++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== exp) begin
          errors++;
          $display("FAIL res_data: got valid=%b data=%h, expected valid=1 data=%h",
                   bus.res_valid, bus.res_data, exp);
        end
        vectors++;
        if (bus.res_pos !== CNT_W'(p) || bus.res_ch !== CNT_W'(c) || bus.res_last !== exp_last) begin
          errors++;
          $display("FAIL res_tags: got pos=%0d ch=%0d last=%b, expected pos=%0d ch=%0d last=%b",
                   bus.res_pos, bus.res_ch, bus.res_last, p, c, exp_last);
        end
        bus.res_ready = 1'b0;
        d = int'($urandom_range(rdy_max, rdy_min));
        repeat (d) begin
          step();
          vectors++;
          if (bus.res_valid !== 1'b1 || bus.res_data !== exp || bus.res_pos !== CNT_W'(p) ||
              bus.res_ch !== CNT_W'(c) || bus.fetch_req !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold: got valid=%b data=%h pos=%0d ch=%0d req=%b, expected 1 %h %0d %0d 0",
                     bus.res_valid, bus.res_data, bus.res_pos, bus.res_ch, bus.fetch_req, exp, p, c);
          end
        end
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
      end
    end
    vectors++;
    if (done !== 1'b1 || busy !== 1'b1 || bus.res_valid !== 1'b0 || bus.fetch_req !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: got done=%b busy=%b valid=%b req=%b, expected 1 1 0 0",
               done, busy, bus.res_valid, bus.fetch_req);
    end
    step();
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_return: got done=%b busy=%b, expected 0 0", done, busy);
    end
  endtask

  task automatic test_order();
    test_layer(2, 3, 0, 0, 0);
  endtask

  task automatic test_backpressure();
    test_layer(1, 2, 0, 5, 5);
  endtask

  // 1x1 layer with a=w=0 so the PE output is exactly the bias; ack is already high before fetch.
  task automatic test_single(input logic [WIDTH-1:0] bias, input logic [WIDTH-1:0] exp);
    cfg_n_pos = CNT_W'(1);
    cfg_n_ch  = CNT_W'(1);
    bus.fetch_a = '0;
    bus.fetch_w = '0;
    bus.fetch_b = bias;
    bus.fetch_ack = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    vectors++;
    if (bus.fetch_req !== 1'b1 || bus.res_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_fetch: got req=%b valid=%b, expected req=1 valid=0", bus.fetch_req, bus.res_valid);
    end
    step();
    bus.fetch_ack = 1'b0;
    bus.fetch_b = $urandom;
    vectors++;
    if (pe_b !== bias || bus.res_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pe_b: got pe_b=%h valid=%b, expected pe_b=%h valid=0", pe_b, bus.res_valid, bias);
    end
    step();
    vectors++;
    if (bus.res_valid !== 1'b1 || bus.res_data !== exp || bus.res_last !== 1'b1) begin
      errors++;
      $display("FAIL single_result: got valid=%b data=%h last=%b, expected valid=1 data=%h last=1",
               bus.res_valid, bus.res_data, bus.res_last, exp);
    end
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    vectors++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL single_done: got done=%b, expected 1", done);
    end
    step();
  endtask

  task automatic test_relu();
`ifdef SEQ_RELU_EN
    test_single(32'hFF000000, 32'h00000000);
`else
    test_single(32'hFF000000, 32'hFF000000);
`endif
  endtask

  task automatic test_zero_cfg(input int np, input int nc);
    cfg_n_pos = CNT_W'(np);
    cfg_n_ch  = CNT_W'(nc);
    start = 1'b1;
    step();
    start = 1'b0;
    vectors++;
    if (done !== 1'b1 || busy !== 1'b1 || bus.fetch_req !== 1'b0) begin
      errors++;
      $display("FAIL zero_cfg_done: got done=%b busy=%b req=%b, expected 1 1 0", done, busy, bus.fetch_req);
    end
    repeat (3) begin
      step();
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0 || bus.fetch_req !== 1'b0 || bus.res_valid !== 1'b0) begin
        errors++;
        $display("FAIL zero_cfg_idle: got done=%b busy=%b req=%b valid=%b, expected 0 0 0 0",
                 done, busy, bus.fetch_req, bus.res_valid);
      end
    end
  endtask

  task automatic test_abort_fetch();
    logic [WIDTH-1:0] old_b;
    cfg_n_pos = CNT_W'(2);
    cfg_n_ch  = CNT_W'(2);
    start = 1'b1;
    step();
    start = 1'b0;
    old_b = pe_b;
    bus.fetch_a = rand_win();
    bus.fetch_w = rand_win();
    bus.fetch_b = ~old_b;
    bus.fetch_ack = 1'b1;
    abort = 1'b1;
    step();
    abort = 1'b0;
    bus.fetch_ack = 1'b0;
    vectors++;
    if (busy !== 1'b0 || bus.fetch_req !== 1'b0 || done !== 1'b0 || pe_b !== old_b) begin
      errors++;
      $display("FAIL abort_fetch: got busy=%b req=%b done=%b pe_b=%h, expected 0 0 0 %h",
               busy, bus.fetch_req, done, pe_b, old_b);
    end
    repeat (4) begin
      step();
      vectors++;
      if (done !== 1'b0 || bus.res_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL abort_quiet: got done=%b valid=%b busy=%b, expected 0 0 0", done, bus.res_valid, busy);
      end
    end
  endtask

  task automatic test_abort_output();
    logic [WIDTH-1:0] exp;
    cfg_n_pos = CNT_W'(1);
    cfg_n_ch  = CNT_W'(2);
    bus.fetch_a = rand_win();
    bus.fetch_w = rand_win();
    bus.fetch_b = $urandom;
    exp = expect_out(pe_fn(bus.fetch_a, bus.fetch_w, bus.fetch_b));
    bus.fetch_ack = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    bus.fetch_ack = 1'b0;
    step();
    abort = 1'b1;
    bus.res_ready = 1'b1;
    step();
    abort = 1'b0;
    bus.res_ready = 1'b0;
    vectors++;
    if (bus.res_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || bus.res_data !== exp) begin
      errors++;
      $display("FAIL abort_output: got valid=%b busy=%b done=%b data=%h, expected 0 0 0 %h",
               bus.res_valid, busy, done, bus.res_data, exp);
    end
    step();
    vectors++;
    if (done !== 1'b0 || bus.fetch_req !== 1'b0) begin
      errors++;
      $display("FAIL abort_output_quiet: got done=%b req=%b, expected 0 0", done, bus.fetch_req);
    end
  endtask

  task automatic test_async_reset();
    cfg_n_pos = CNT_W'(1);
    cfg_n_ch  = CNT_W'(1);
    bus.fetch_a = rand_win();
    bus.fetch_w = rand_win();
    bus.fetch_b = $urandom;
    bus.fetch_ack = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    bus.fetch_ack = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (outs_set() !== 0) begin
      errors++;
      $display("FAIL async_reset: %0d output bits set, expected 0", outs_set());
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    vectors++;
    if (busy !== 1'b0 || bus.res_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_release: got busy=%b valid=%b, expected 0 0", busy, bus.res_valid);
    end
  endtask

  task automatic test_random();
    repeat (8) test_layer(int'($urandom_range(3, 1)), int'($urandom_range(3, 1)), 3, 0, 3);
    test_layer(3, 1, 2, 0, 2);
    test_layer(1, 4, 2, 0, 2);
  endtask

  initial begin
    bus.fetch_ack = 1'b0;
    bus.fetch_a   = '0;
    bus.fetch_w   = '0;
    bus.fetch_b   = '0;
    bus.res_ready = 1'b0;
    test_reset();
    test_order();
    test_single(32'h01000000, 32'h01000000);
    test_relu();
    test_backpressure();
    test_zero_cfg(3, 0);
    test_zero_cfg(0, 2);
    test_abort_fetch();
    test_abort_output();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
